riscv_core_dpath_load_resp_queue: RTL and testbench
===================================================

Name: riscv_core_dpath_load_resp_queue

Overview:
- Parametrised load-response buffer for the long-pipeline datapath.
- Successor of the single-register dmem response queue in the M stage: N entries, val/rdy on both sides, and byte-lane alignment by address offset.
- Subword extraction is applied on the enqueue side, so stored entries are already writeback-ready.
- Sits between the data memory response port and the M-stage ALU/load mux. It lets memory responses arrive while M is stalled without losing data.

Parameters:
- DATA_W, 32, data width in bits; legal values are 32 and 64.
- DEPTH, 2, number of storage entries; must be at least 1.
- BYPASS, 1, if 1, an enqueue into an empty queue may be dequeued in the same cycle.
- PIPE, 0, if 1, enq_rdy is asserted when full and deq fires in the same cycle.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries.
- enq_val  in  1  memory response valid.
- enq_rdy  out  1  queue can accept a response.
- enq_data  in  DATA_W  raw memory response data.
- enq_type  in  3  extraction type: 0 full, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwu, 7 reserved.
- enq_offset  in  log2(DATA_W/8)  byte offset, i.e. the low address bits of the request.
- deq_val  out  1  head entry valid.
- deq_rdy  in  1  consumer (M stage, not stalled) accepts.
- deq_data  out  DATA_W  extracted, extended result.
- count  out  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset=0, asynchronous): head=0, tail=0, count=0. Outputs: deq_val=0, enq_rdy=1, deq_data=0. Entry storage is not reset.
- Extraction (combinational on the enq side):
  - shifted = enq_data >> (enq_offset*8).
  - lb/lh/lw: sign-extend shifted[7:0], [15:0] or [31:0] to DATA_W.
  - lbu/lhu/lwu: zero-extend the same fields.
  - full: pass enq_data unshifted.
  - Type 5/6 with DATA_W=32 behaves as full.
  - Type 7 stores all-zero data.
  - Offsets whose access would cross the word boundary are not checked; upper bytes shift in as zero.
- Handshake: enq fires when enq_val && enq_rdy; deq fires when deq_val && deq_rdy.
- enq_rdy = !flush && (count<DEPTH || (PIPE && deq_rdy && count==DEPTH)).
- deq_val = !flush && (count>0 || (BYPASS && count==0 && enq_val)).
- deq_data: the head entry when count>0; the extracted enq data when bypassing.
- Bypass fire (count==0, enq and deq both fire): nothing is written and count stays 0.
- Storage: circular buffer. tail advances on a non-bypassed enq; head advances on a deq from storage. Both wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
- Count update:
  - enq only: +1.
  - deq only: -1.
  - both fire with count>0: unchanged, with head and tail both advancing.
  - both fire while bypassing: 0.
- Flush (synchronous, highest priority): during the flush cycle enq_rdy=0 and deq_val=0, so no transfer fires. On the next edge head=tail=count=0.
- Full with PIPE=0: enq_rdy=0 regardless of deq_rdy. The producer must hold enq_val and enq_data stable until enq_rdy.
- Latency:
  - BYPASS=1 and empty: 0 cycles.
  - Otherwise: 1 cycle from the enq edge to deq_val.
- Order is strictly FIFO.
- Reset during operation discards all contents immediately (asynchronously). The first enqueue after reset release is accepted on the first rising edge.

Test Plan:
- Reset, then with BYPASS=1, enq type 0 data 0xDEADBEEF and deq_rdy=1 in the same cycle -> deq_val=1 and deq_data=0xDEADBEEF in that cycle; count stays 0.
- DATA_W=32, enq 0x80FF7F01 with type 1 at offsets 0,1,2,3 and deq_rdy=0 -> count reaches 2 at DEPTH=2 and enq_rdy drops.
  - Repeat with DEPTH=4 so all four entries are stored; then dequeuing returns 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80 in order.
- Type 4 with offset 2 on 0xABCD1234 -> deq_data 0x0000ABCD.
- Type 3 with offset 2 on the same data -> deq_data 0xFFFFABCD.
- DEPTH=2, PIPE=0, full, enq_val=1 and deq_rdy=1 -> enq_rdy=0 and one deq fires; the next cycle accepts the enq.
  - Same stimulus with PIPE=1 -> both fire in one cycle and count stays 2.
- DEPTH=3, 10 back-to-back enq/deq with random stalls on values 1..10 -> output 1..10 in order; pointers wrap correctly at 3.
- Count=2 then flush=1 with enq_val=1 -> enq_rdy=0 and deq_val=0 that cycle; count=0 next cycle.
  - Assert reset low mid-burst -> deq_val=0 immediately and count=0.

Source files
------------

// File: rtl/riscv_core_dpath_load_resp_queue.sv
// Load-response queue between the dmem response port and the M-stage load mux.
// Subword extraction happens on enqueue, so every stored entry is already writeback-ready.
module riscv_core_dpath_load_resp_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 1,
  parameter int PIPE   = 0,
  localparam int OFF_W = $clog2(DATA_W/8),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              enq_val,
  output logic              enq_rdy,
  input  logic [DATA_W-1:0] enq_data,
  input  logic [2:0]        enq_type,
  input  logic [OFF_W-1:0]  enq_offset,
  output logic              deq_val,
  input  logic              deq_rdy,
  output logic [DATA_W-1:0] deq_data,
  output logic [CNT_W-1:0]  count
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  localparam logic [2:0] T_FULL = 3'd0;
  localparam logic [2:0] T_LB   = 3'd1;
  localparam logic [2:0] T_LBU  = 3'd2;
  localparam logic [2:0] T_LH   = 3'd3;
  localparam logic [2:0] T_LHU  = 3'd4;
  localparam logic [2:0] T_LW   = 3'd5;
  localparam logic [2:0] T_LWU  = 3'd6;

  // Word-sized types on a 32-bit datapath degenerate to a full, unshifted pass.
  function automatic logic [DATA_W-1:0] extract(
    input logic [DATA_W-1:0] data,
    input logic [2:0]        typ,
    input logic [OFF_W-1:0]  off
  );
    logic [DATA_W-1:0]  sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    sh = data >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (typ)
      T_FULL:  extract = data;
      T_LB:    extract = DATA_W'(b);
      T_LBU:   extract = DATA_W'(sh[7:0]);
      T_LH:    extract = DATA_W'(h);
      T_LHU:   extract = DATA_W'(sh[15:0]);
      T_LW:    extract = (DATA_W == 32) ? data : DATA_W'(w);
      T_LWU:   extract = (DATA_W == 32) ? data : DATA_W'(sh[31:0]);
      default: extract = '0;
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] w_ext;
  logic              w_empty;
  logic              w_full;
  logic              w_enq_fire;
  logic              w_deq_fire;
  logic              w_bypass;
  logic              w_wr;
  logic              w_rd;

  assign w_ext   = extract(enq_data, enq_type, enq_offset);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL);

  assign enq_rdy = !flush && (!w_full || ((PIPE != 0) && deq_rdy));
  assign deq_val = !flush && (!w_empty || ((BYPASS != 0) && enq_val));

  assign w_enq_fire = enq_val && enq_rdy;
  assign w_deq_fire = deq_val && deq_rdy;
  // A dequeue from an empty queue can only be the bypass path; it touches no storage.
  assign w_bypass   = w_empty && w_deq_fire;
  assign w_wr       = w_enq_fire && !w_bypass;
  assign w_rd       = w_deq_fire && !w_bypass;

  always_comb begin
    deq_data = '0;
    if (!w_empty) begin
      deq_data = r_mem[r_head];
    end else if ((BYPASS != 0) && enq_val) begin
      deq_data = w_ext;
    end
  end

  assign count = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_tail <= next_ptr(r_tail);
      end
      if (w_rd) begin
        r_head <= next_ptr(r_head);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries data only and is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_tail] <= w_ext;
    end
  end

endmodule

// File: tb/tb_riscv_core_dpath_load_resp_queue.sv
// Directed bench for the load-response queue across DEPTH/BYPASS/PIPE variants.
module tb_riscv_core_dpath_load_resp_queue;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  // a: DEPTH=2 BYPASS=1 PIPE=0
  logic        a_flush, a_enq_val, a_enq_rdy, a_deq_val, a_deq_rdy;
  logic [31:0] a_enq_data, a_deq_data;
  logic [2:0]  a_enq_type;
  logic [1:0]  a_enq_offset, a_count;
  // b: DEPTH=4 BYPASS=1 PIPE=0
  logic        b_enq_val, b_enq_rdy, b_deq_val, b_deq_rdy;
  logic [31:0] b_enq_data, b_deq_data;
  logic [2:0]  b_enq_type, b_count;
  logic [1:0]  b_enq_offset;
  // c: DEPTH=2 BYPASS=1 PIPE=1
  logic        c_enq_val, c_enq_rdy, c_deq_val, c_deq_rdy;
  logic [31:0] c_enq_data, c_deq_data;
  logic [1:0]  c_count;
  // d: DEPTH=3 BYPASS=0 PIPE=0
  logic        d_enq_val, d_enq_rdy, d_deq_val, d_deq_rdy;
  logic [31:0] d_enq_data, d_deq_data;
  logic [2:0]  d_count;

  logic [31:0] lb_exp [4];

  riscv_core_dpath_load_resp_queue #(.DATA_W(32), .DEPTH(2), .BYPASS(1), .PIPE(0)) u_a (
    .clk(clk), .reset(rst_n), .flush(a_flush), .enq_val(a_enq_val), .enq_rdy(a_enq_rdy),
    .enq_data(a_enq_data), .enq_type(a_enq_type), .enq_offset(a_enq_offset),
    .deq_val(a_deq_val), .deq_rdy(a_deq_rdy), .deq_data(a_deq_data), .count(a_count));

  riscv_core_dpath_load_resp_queue #(.DATA_W(32), .DEPTH(4), .BYPASS(1), .PIPE(0)) u_b (
    .clk(clk), .reset(rst_n), .flush(1'b0), .enq_val(b_enq_val), .enq_rdy(b_enq_rdy),
    .enq_data(b_enq_data), .enq_type(b_enq_type), .enq_offset(b_enq_offset),
    .deq_val(b_deq_val), .deq_rdy(b_deq_rdy), .deq_data(b_deq_data), .count(b_count));

  riscv_core_dpath_load_resp_queue #(.DATA_W(32), .DEPTH(2), .BYPASS(1), .PIPE(1)) u_c (
    .clk(clk), .reset(rst_n), .flush(1'b0), .enq_val(c_enq_val), .enq_rdy(c_enq_rdy),
    .enq_data(c_enq_data), .enq_type(3'd0), .enq_offset(2'd0),
    .deq_val(c_deq_val), .deq_rdy(c_deq_rdy), .deq_data(c_deq_data), .count(c_count));

  riscv_core_dpath_load_resp_queue #(.DATA_W(32), .DEPTH(3), .BYPASS(0), .PIPE(0)) u_d (
    .clk(clk), .reset(rst_n), .flush(1'b0), .enq_val(d_enq_val), .enq_rdy(d_enq_rdy),
    .enq_data(d_enq_data), .enq_type(3'd0), .enq_offset(2'd0),
    .deq_val(d_deq_val), .deq_rdy(d_deq_rdy), .deq_data(d_deq_data), .count(d_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt;
    int got;
    n_vec = 0;
    n_err = 0;
    lb_exp = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
    a_flush = 0; a_enq_val = 0; a_deq_rdy = 0; a_enq_data = 0; a_enq_type = 0; a_enq_offset = 0;
    b_enq_val = 0; b_deq_rdy = 0; b_enq_data = 0; b_enq_type = 0; b_enq_offset = 0;
    c_enq_val = 0; c_deq_rdy = 0; c_enq_data = 0;
    d_enq_val = 0; d_deq_rdy = 0; d_enq_data = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_deq_val", a_deq_val, 0);
    chk("rst_enq_rdy", a_enq_rdy, 1);
    chk("rst_deq_data", a_deq_data, 0);
    chk("rst_count", a_count, 0);
    chk("rst_count_d", d_count, 0);
    #10 rst_n = 1'b1;
    tick();

    // zero-latency bypass into an empty queue
    a_enq_val = 1; a_enq_type = 0; a_enq_data = 32'hDEAD_BEEF; a_deq_rdy = 1;
    #1;
    chk("byp_deq_val", a_deq_val, 1);
    chk("byp_deq_data", a_deq_data, 32'hDEAD_BEEF);
    tick();
    chk("byp_count", a_count, 0);

    // lb at successive offsets fills the 2-deep queue
    a_deq_rdy = 0; a_enq_data = 32'h80FF_7F01; a_enq_type = 1; a_enq_offset = 0;
    tick();
    chk("lb2_count1", a_count, 1);
    a_enq_offset = 1;
    tick();
    chk("lb2_count2", a_count, 2);
    a_enq_offset = 2;
    #1;
    chk("lb2_full_rdy", a_enq_rdy, 0);
    chk("lb2_head", a_deq_data, 32'h0000_0001);
    tick();
    chk("lb2_count_hold", a_count, 2);

    // full with PIPE=0: only the dequeue fires, enqueue lands next cycle
    a_enq_type = 0; a_enq_offset = 0; a_enq_data = 32'h1111_1111; a_deq_rdy = 1;
    #1;
    chk("full_enq_rdy", a_enq_rdy, 0);
    chk("full_deq_val", a_deq_val, 1);
    tick();
    chk("full_cnt_after", a_count, 1);
    chk("full_head2", a_deq_data, 32'h0000_007F);
    chk("full_rdy_back", a_enq_rdy, 1);
    tick();
    chk("both_cnt", a_count, 1);
    chk("both_head", a_deq_data, 32'h1111_1111);
    a_enq_val = 0;
    tick();
    chk("drain_cnt", a_count, 0);
    chk("drain_deq_val", a_deq_val, 0);

    // flush squashes everything and blocks transfers that cycle
    a_deq_rdy = 0; a_enq_val = 1; a_enq_data = 32'hA;
    tick();
    a_enq_data = 32'hB;
    tick();
    chk("flush_pre_cnt", a_count, 2);
    a_flush = 1; a_deq_rdy = 1;
    #1;
    chk("flush_enq_rdy", a_enq_rdy, 0);
    chk("flush_deq_val", a_deq_val, 0);
    tick();
    a_flush = 0; a_enq_val = 0; a_deq_rdy = 0;
    #1;
    chk("flush_cnt", a_count, 0);
    chk("flush_deq_val_after", a_deq_val, 0);

    // four lb entries at DEPTH=4 come back in order
    b_enq_val = 1; b_enq_type = 1; b_enq_data = 32'h80FF_7F01;
    for (int i = 0; i < 4; i++) begin
      b_enq_offset = 2'(i);
      tick();
    end
    b_enq_val = 0;
    #1;
    chk("lb4_count", b_count, 4);
    chk("lb4_full_rdy", b_enq_rdy, 0);
    b_deq_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lb4_order", b_deq_data, lb_exp[i]);
      tick();
    end
    chk("lb4_empty", b_count, 0);

    // halfword extraction at offset 2
    b_deq_rdy = 0; b_enq_val = 1; b_enq_data = 32'hABCD_1234; b_enq_type = 4; b_enq_offset = 2;
    tick();
    b_enq_type = 3;
    tick();
    b_enq_val = 0;
    #1;
    chk("lh_count", b_count, 2);
    chk("lhu_data", b_deq_data, 32'h0000_ABCD);
    b_deq_rdy = 1;
    tick();
    chk("lh_data", b_deq_data, 32'hFFFF_ABCD);
    tick();
    chk("lh_empty", b_count, 0);

    // remaining extraction types observed through the bypass path
    b_enq_val = 1; b_enq_data = 32'h1234_5678; b_enq_type = 5; b_enq_offset = 1;
    #1 chk("lw32_full", b_deq_data, 32'h1234_5678);
    b_enq_type = 6; b_enq_offset = 3;
    #1 chk("lwu32_full", b_deq_data, 32'h1234_5678);
    b_enq_type = 7;
    #1 chk("rsvd_zero", b_deq_data, 32'h0);
    b_enq_data = 32'h80FF_7F01; b_enq_type = 2; b_enq_offset = 3;
    #1 chk("lbu_off3", b_deq_data, 32'h0000_0080);
    b_enq_type = 0; b_enq_offset = 2;
    #1 chk("full_noshift", b_deq_data, 32'h80FF_7F01);
    b_enq_val = 0; b_deq_rdy = 0;

    // PIPE=1: full queue accepts while dequeuing
    c_enq_val = 1; c_enq_data = 32'h1;
    tick();
    c_enq_data = 32'h2;
    tick();
    c_enq_data = 32'h3;
    #1;
    chk("pipe_count", c_count, 2);
    chk("pipe_stall_rdy", c_enq_rdy, 0);
    c_deq_rdy = 1;
    #1;
    chk("pipe_enq_rdy", c_enq_rdy, 1);
    chk("pipe_head", c_deq_data, 32'h1);
    tick();
    chk("pipe_cnt_hold", c_count, 2);
    chk("pipe_head2", c_deq_data, 32'h2);
    c_enq_val = 0;
    tick();
    chk("pipe_head3", c_deq_data, 32'h3);
    tick();
    chk("pipe_empty", c_count, 0);
    c_deq_rdy = 0;

    // DEPTH=3, no bypass: one-cycle latency, then 1..10 with random stalls
    d_enq_val = 1; d_enq_data = 32'd1; d_deq_rdy = 1;
    #1;
    chk("nobyp_deq_val", d_deq_val, 0);
    tick();
    chk("lat1_deq_val", d_deq_val, 1);
    chk("lat1_deq_data", d_deq_data, 32'd1);
    nxt = 2;
    got = 1;
    for (int cyc = 0; cyc < 400 && got <= 10; cyc++) begin
      d_enq_val  = (nxt <= 10) && ($urandom_range(0, 3) != 0);
      d_enq_data = 32'(nxt);
      d_deq_rdy  = ($urandom_range(0, 2) == 0);
      #1;
      chk("wrap_cnt_le3", 64'(d_count <= 3), 1);
      if (d_deq_val && d_deq_rdy) begin
        chk("wrap_order", d_deq_data, 64'(got));
        got++;
      end
      if (d_enq_val && d_enq_rdy) nxt++;
      tick();
    end
    chk("wrap_all_out", 64'(got), 64'd11);
    d_enq_val = 0; d_deq_rdy = 0;

    // asynchronous reset in the middle of a burst
    a_enq_val = 1; a_enq_type = 0; a_enq_offset = 0; a_enq_data = 32'h5;
    tick();
    a_enq_data = 32'h6;
    tick();
    a_enq_val = 0;
    #1;
    chk("mid_pre_cnt", a_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_deq_val", a_deq_val, 0);
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_enq_rdy", a_enq_rdy, 1);
    #3 rst_n = 1'b1;
    a_enq_val = 1; a_enq_data = 32'h77;
    tick();
    chk("post_rst_cnt", a_count, 1);
    chk("post_rst_data", a_deq_data, 32'h77);
    a_enq_val = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
